// File: rtl/s2_unidade_controle_param.sv
// Game control unit: owns sequence address, round, lives, error and score counters.
// Supports normal, training and reverse-play modes; outputs are Moore decodes of the state.
module s2_unidade_controle_param #(
   parameter int ADDR_W    = 4,
   parameter int N_ROUNDS  = 16,
   parameter int MAX_LIVES = 3,
   parameter int ERR_W     = 3,
   parameter int SCORE_W   = 8,
   parameter int PTS_ROUND = 10,
   parameter int PTS_ERR   = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               jogar,
   input  logic [1:0]         modo,
   input  logic               botoesIgualMemoria,
   input  logic               jogada,
   input  logic               timeout,
   input  logic               muda_leds,
   output logic [ADDR_W-1:0]  endereco,
   output logic [ADDR_W-1:0]  limite,
   output logic [2:0]         vidas,
   output logic [ERR_W-1:0]   erros_rodada,
   output logic [SCORE_W-1:0] pontos,
   output logic               zeraT,
   output logic               contaT,
   output logic               zeraT2,
   output logic               contaT2,
   output logic               zeraR,
   output logic               registraR,
   output logic               mostraJ,
   output logic               mostraB,
   output logic               pronto,
   output logic               acertou,
   output logic               perdeu,
   output logic               serrou,
   output logic [4:0]         db_estado
);

   if (N_ROUNDS < 1 || N_ROUNDS > 2**ADDR_W) begin : g_chk_rounds
      $error("N_ROUNDS must lie in 1..2**ADDR_W");
   end
   if (MAX_LIVES < 1 || MAX_LIVES > 7) begin : g_chk_lives
      $error("MAX_LIVES must lie in 1..7");
   end

   typedef enum logic [4:0] {
      INICIAL     = 5'h00, PREPARACAO = 5'h01, PROX_RODADA = 5'h02, ESPERA      = 5'h03,
      REGISTRA    = 5'h04, COMPARA    = 5'h05, PROXIMO     = 5'h06, MOSTRA      = 5'h07,
      APAGA       = 5'h08, INC_MOSTRA = 5'h09, FIM_ACERTOU = 5'h0A, FIM_RODADA  = 5'h0B,
      PREP_JOG    = 5'h0C, FIM_DERROTA = 5'h0D, ERROU      = 5'h0E, SOMA        = 5'h10,
      TREINO      = 5'h14
   } estado_t;

   localparam logic [ADDR_W-1:0]  ULTIMA_RODADA = ADDR_W'(N_ROUNDS - 1);
   localparam logic [SCORE_W-1:0] PONTOS_MAX    = '1;
   localparam logic [ERR_W-1:0]   ERROS_MAX     = '1;

   estado_t     estado, prox;
   logic [1:0]  modo_r;
   logic        rev, ultimo;
   logic [31:0] desconto, ganho, soma;
   logic [SCORE_W-1:0] pontos_novo;

   assign rev    = (modo_r == 2'b10);
   assign ultimo = rev ? (endereco == '0) : (endereco == limite);

   // Bit order: zeraT contaT zeraT2 contaT2 zeraR registraR mostraJ mostraB pronto acertou perdeu serrou
   function automatic logic [11:0] decodifica(input estado_t s);
      case (s)
         PREPARACAO:  return 12'b1010_1000_0000;
         PROX_RODADA: return 12'b1010_0000_0000;
         ESPERA:      return 12'b0100_0001_0000;
         REGISTRA:    return 12'b0000_0100_0000;
         COMPARA:     return 12'b0010_0001_0000;
         PROXIMO:     return 12'b1000_0000_0000;
         MOSTRA:      return 12'b0001_0010_0000;
         APAGA:       return 12'b0001_0000_0000;
         FIM_ACERTOU: return 12'b0000_0000_1100;
         FIM_RODADA:  return 12'b0001_0001_0000;
         PREP_JOG:    return 12'b1000_0000_0000;
         FIM_DERROTA: return 12'b0000_0000_1010;
         ERROU:       return 12'b0010_0000_0001;
         TREINO:      return 12'b0000_0001_0000;
         default:     return 12'b0000_0000_0000;
      endcase
   endfunction

   // Round score: never negative, then saturate the running total.
   always_comb begin
      desconto = 32'(erros_rodada) * 32'(PTS_ERR);
      ganho    = (desconto >= 32'(PTS_ROUND)) ? 32'd0 : 32'(PTS_ROUND) - desconto;
      soma     = 32'(pontos) + ganho;
      pontos_novo = (soma > 32'(PONTOS_MAX)) ? PONTOS_MAX : soma[SCORE_W-1:0];
   end

   always_comb begin
      prox = estado;
      case (estado)
         INICIAL:     if (jogar) prox = PREPARACAO;
         PREPARACAO:  prox = (modo_r == 2'b01) ? TREINO : MOSTRA;
         MOSTRA:      if (muda_leds) prox = APAGA;
         APAGA:       if (muda_leds) prox = (endereco == limite) ? PREP_JOG : INC_MOSTRA;
         INC_MOSTRA:  prox = MOSTRA;
         PREP_JOG:    prox = ESPERA;
         ESPERA: begin
            if (timeout)     prox = ERROU;
            else if (jogada) prox = REGISTRA;
         end
         REGISTRA:    prox = COMPARA;
         COMPARA: begin
            if (!botoesIgualMemoria) prox = ERROU;
            else if (ultimo)         prox = FIM_RODADA;
            else                     prox = PROXIMO;
         end
         PROXIMO:     prox = ESPERA;
         ERROU:       prox = (vidas == 3'd1) ? FIM_DERROTA : MOSTRA;
         FIM_RODADA:  if (muda_leds) prox = SOMA;
         SOMA:        prox = (limite == ULTIMA_RODADA) ? FIM_ACERTOU : PROX_RODADA;
         PROX_RODADA: prox = MOSTRA;
         FIM_ACERTOU, FIM_DERROTA: if (jogar) prox = PREPARACAO;
         TREINO:      if (jogar) prox = INICIAL;
         default:     prox = INICIAL;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado       <= INICIAL;
         modo_r       <= 2'b00;
         endereco     <= '0;
         limite       <= '0;
         vidas        <= 3'd0;
         erros_rodada <= '0;
         pontos       <= '0;
         {zeraT, contaT, zeraT2, contaT2, zeraR, registraR,
          mostraJ, mostraB, pronto, acertou, perdeu, serrou} <= 12'b0;
      end else begin
         estado <= prox;
         {zeraT, contaT, zeraT2, contaT2, zeraR, registraR,
          mostraJ, mostraB, pronto, acertou, perdeu, serrou} <= decodifica(prox);
         // Counters change on the edge that leaves the state owning them.
         case (estado)
            INICIAL, FIM_ACERTOU, FIM_DERROTA: if (jogar) modo_r <= modo;
            PREPARACAO: begin
               endereco     <= '0;
               limite       <= '0;
               erros_rodada <= '0;
               pontos       <= '0;
               vidas        <= 3'(MAX_LIVES);
            end
            INC_MOSTRA: endereco <= endereco + ADDR_W'(1);
            PREP_JOG:   endereco <= rev ? limite : '0;
            PROXIMO:    endereco <= rev ? endereco - ADDR_W'(1) : endereco + ADDR_W'(1);
            ERROU: begin
               if (erros_rodada != ERROS_MAX) erros_rodada <= erros_rodada + ERR_W'(1);
               vidas    <= vidas - 3'd1;
               endereco <= '0;
            end
            SOMA:       pontos <= pontos_novo;
            PROX_RODADA: begin
               limite       <= limite + ADDR_W'(1);
               endereco     <= '0;
               erros_rodada <= '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      db_estado = 5'h0F;
      case (estado)
         INICIAL, PREPARACAO, PROX_RODADA, ESPERA, REGISTRA, COMPARA, PROXIMO, MOSTRA,
         APAGA, INC_MOSTRA, FIM_ACERTOU, FIM_RODADA, PREP_JOG, FIM_DERROTA, ERROU,
         SOMA, TREINO: db_estado = estado;
         default: ;
      endcase
   end

endmodule
